branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

Registered, parametrised branch/jump resolution stage for the pipelined OTTER core; it supersedes the bare comparator. It takes decoded control-transfer operands from the execute stage, evaluates the RV32I branch condition selected by funct3, computes the resolved next PC and compares it against the fetch-stage prediction. The result is held in one output register under a valid/ready handshake. Saturating counters record resolved control transfers and mispredicts for the performance CSRs.

## Interface
- XLEN, 32: operand, PC and target width (≥ 8).
- CNT_W, 16: width of each performance counter.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  unit can accept a bundle this cycle.
- is_branch  in  1  conditional branch (B-type).
- is_jal  in  1  JAL.
- is_jalr  in  1  JALR.
- funct3  in  3  branch condition select.
- pc  in  XLEN  instruction PC.
- rs1, rs2  in  XLEN  register operands.
- imm  in  XLEN  sign-extended immediate.
- pred_taken  in  1  fetch prediction: taken.
- pred_target  in  XLEN  fetch-predicted target.
- out_valid  out  1  result register holds a result.
- out_ready  in  1  consumer accepts the result.
- taken  out  1  resolved taken.
- next_pc  out  XLEN  resolved next PC.
- mispredict  out  1  prediction wrong; a pipeline flush is required.
- misaligned  out  1  taken target has bit 1 set.
- illegal  out  1  is_branch with funct3 010 or 011.
- br_count  out  CNT_W  resolved control transfers (saturating).
- mis_count  out  CNT_W  mispredicts (saturating).

## Operation
- Accept: in_valid && in_ready. in_ready = !out_valid || out_ready.
- Compare: eq = rs1==rs2; lt = signed rs1<rs2; ltu = unsigned rs1<rs2.
- funct3 (is_branch): 000 eq, 001 !eq, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
  - 010 and 011: taken=0 and illegal=1.
- is_jal or is_jalr: taken=1 regardless of funct3.
- No control flag set: taken=0. The bundle still passes through, but no counter increments.
- Control flags are mutually exclusive; if more than one is set, priority is jalr > jal > branch.
- Target width rule: all adds are XLEN-bit modulo 2^XLEN; wrap-around is silent.
  - Branch and JAL target: pc+imm.
  - JALR target: (rs1+imm) with bit 0 cleared.
  - Not taken: pc+4.
- mispredict = (taken != pred_taken) || (taken && next_pc != pred_target).
- misaligned = taken && next_pc[1]. It is reported only; mispredict is still computed normally.
- Counters update on the output handshake (out_valid && out_ready) of a bundle that had any control flag set.
  - br_count += 1.
  - mis_count += 1 when mispredict is set.
  - Each counter holds at 2^CNT_W−1.

## Timing
- Latency: one cycle. A bundle accepted at edge N appears with out_valid=1 after edge N.
- Hold: while out_valid && !out_ready, every output is held stable and in_ready=0.
- Back-to-back: simultaneous output handshake and input accept in the same cycle gives full throughput. The register reloads; out_valid stays 1.
- Output handshake without a new input: out_valid falls to 0.
- Reset values: out_valid=0; taken, mispredict, misaligned, illegal=0; next_pc=0; br_count=0; mis_count=0.
- in_ready is 1 in the cycle after reset.
- Reset mid-operation: a held, unconsumed result is discarded and not counted. rst has priority over any handshake in the same cycle.
- Counters become visible one cycle after the counted output handshake.

## Structure
- Shared package otter_pkg holds:
  - funct3 constants: BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU.
  - The default XLEN.
- One sub-module, branch_cmp. It is parametrised by XLEN, is purely combinational, produces eq/lt/ltu, and is instantiated once.
- Taken/target logic, the result register and the counters stay in the top module.

## Test plan
- BLT, rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20, pred_taken=0 → taken=1, next_pc=0x120, mispredict=1. BLTU with the same operands → taken=0, next_pc=0x104.
- JALR, rs1=0x1003, imm=0x4, pred_taken=1, pred_target=0x1006 → next_pc=0x1006, mispredict=0, misaligned=1.
- Back-pressure: hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs stable. Release → two results in consecutive cycles; br_count increments by 2.
- Wrap: pc=0xFFFFFFFC, BEQ not taken → next_pc=0x00000000. funct3=010 → illegal=1, taken=0.
- CNT_W=2: 5 mispredicted branches → both counters saturate at 3.
- Assert rst while a result is held → out_valid=0 next cycle and counters=0.

Source files
------------

// File: rtl/otter_pkg.sv
// otter_pkg: shared OTTER constants (branch funct3 encodings, default XLEN)
package otter_pkg;
  localparam int XLEN_DEF = 32;
  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;
endpackage

// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: operand bundle in, resolved result and perf counters out
interface branch_resolve_unit_if
  import otter_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 16
);
  logic             in_valid, in_ready, is_branch, is_jal, is_jalr, pred_taken;
  logic [2:0]       funct3;
  logic [XLEN-1:0]  pc, rs1, rs2, imm, pred_target;
  logic             out_valid, out_ready, taken, mispredict, misaligned, illegal;
  logic [XLEN-1:0]  next_pc;
  logic [CNT_W-1:0] br_count, mis_count;
  modport master (
    output in_valid, is_branch, is_jal, is_jalr, funct3, pc, rs1, rs2, imm,
           pred_taken, pred_target, out_ready,
    input  in_ready, out_valid, taken, next_pc, mispredict, misaligned, illegal,
           br_count, mis_count
  );
  modport slave (
    input  in_valid, is_branch, is_jal, is_jalr, funct3, pc, rs1, rs2, imm,
           pred_taken, pred_target, out_ready,
    output in_ready, out_valid, taken, next_pc, mispredict, misaligned, illegal,
           br_count, mis_count
  );
endinterface

// File: rtl/branch_cmp.sv
// branch_cmp: combinational equality, signed and unsigned less-than
module branch_cmp #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            eq,
  output logic            lt,
  output logic            ltu
);
  assign eq  = a == b;
  assign lt  = $signed(a) < $signed(b);
  assign ltu = a < b;
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: registered branch/jump resolution with mispredict detection and perf counters
module branch_resolve_unit
  import otter_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 16
) (
  input logic                 clk,
  input logic                 rst,
  branch_resolve_unit_if.slave bus
);
  logic            eq, lt, ltu, br_cond, is_br, take, ill, mis, ctl, ctl_q;
  logic [XLEN-1:0] tgt, npc;
  branch_cmp #(.XLEN(XLEN)) u_cmp (.a(bus.rs1), .b(bus.rs2), .eq, .lt, .ltu);
  always_comb begin
    br_cond = bus.funct3 == BR_EQ  ? eq   :
              bus.funct3 == BR_NE  ? !eq  :
              bus.funct3 == BR_LT  ? lt   :
              bus.funct3 == BR_GE  ? !lt  :
              bus.funct3 == BR_LTU ? ltu  :
              bus.funct3 == BR_GEU ? !ltu : 1'b0;
    is_br = bus.is_branch && !bus.is_jal && !bus.is_jalr;
    ill   = is_br && bus.funct3[2:1] == 2'b01;
    take  = bus.is_jalr || bus.is_jal || (is_br && br_cond);
    tgt   = bus.is_jalr ? ((bus.rs1 + bus.imm) & ~XLEN'(1)) : bus.pc + bus.imm;
    npc   = take ? tgt : bus.pc + XLEN'(4);
    mis   = (take != bus.pred_taken) || (take && npc != bus.pred_target);
    ctl   = bus.is_branch || bus.is_jal || bus.is_jalr;
  end
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  // counters follow the consumed result, so they trail the output handshake by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid  <= 1'b0;
      bus.taken      <= 1'b0;
      bus.next_pc    <= '0;
      bus.mispredict <= 1'b0;
      bus.misaligned <= 1'b0;
      bus.illegal    <= 1'b0;
      bus.br_count   <= '0;
      bus.mis_count  <= '0;
      ctl_q          <= 1'b0;
    end else begin
      if (bus.out_valid && bus.out_ready && ctl_q) begin
        bus.br_count  <= bus.br_count + CNT_W'(bus.br_count != '1);
        bus.mis_count <= bus.mis_count + CNT_W'(bus.mispredict && bus.mis_count != '1);
      end
      if (bus.in_valid && bus.in_ready) begin
        bus.out_valid  <= 1'b1;
        bus.taken      <= take;
        bus.next_pc    <= npc;
        bus.mispredict <= mis;
        bus.misaligned <= take && npc[1];
        bus.illegal    <= ill;
        ctl_q          <= ctl;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed tests for branch_resolve_unit (16-bit and 2-bit counter instances)
module tb_branch_resolve_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  branch_resolve_unit_if #(.XLEN(32), .CNT_W(16)) bus ();
  branch_resolve_unit_if #(.XLEN(32), .CNT_W(2))  bus2 ();
  branch_resolve_unit #(.XLEN(32), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
  branch_resolve_unit #(.XLEN(32), .CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic br, input logic jal, input logic jalr,
                       input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm, input logic pt,
                       input logic [31:0] ptgt);
    bus.in_valid = v; bus.is_branch = br; bus.is_jal = jal; bus.is_jalr = jalr;
    bus.funct3 = f3; bus.pc = pc; bus.rs1 = rs1; bus.rs2 = rs2; bus.imm = imm;
    bus.pred_taken = pt; bus.pred_target = ptgt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
    bus.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.out_ready = 1'b1; bus2.is_branch = 1'b0; bus2.is_jal = 1'b0;
    bus2.is_jalr = 1'b0; bus2.funct3 = 3'b000; bus2.pc = '0; bus2.rs1 = '0; bus2.rs2 = '0;
    bus2.imm = '0; bus2.pred_taken = 1'b0; bus2.pred_target = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.taken !== 1'b0) begin errors++; $display("FAIL reset taken: got %b want 0", bus.taken); end
    checks++; if (bus.next_pc !== 32'h0) begin errors++; $display("FAIL reset next_pc: got %h want 0", bus.next_pc); end
    checks++; if ({bus.mispredict, bus.misaligned, bus.illegal} !== 3'b000) begin errors++; $display("FAIL reset flags: got %b want 000", {bus.mispredict, bus.misaligned, bus.illegal}); end
    checks++; if (bus.br_count !== 16'd0 || bus.mis_count !== 16'd0) begin errors++; $display("FAIL reset counters: got %0d/%0d want 0/0", bus.br_count, bus.mis_count); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_blt_bltu();
    drive(1, 1, 0, 0, 3'b100, 32'h100, 32'hFFFFFFFF, 32'h1, 32'h20, 0, 0);
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL blt out_valid: got %b want 1", bus.out_valid); end
    checks++; if (bus.taken !== 1'b1) begin errors++; $display("FAIL blt taken: got %b want 1", bus.taken); end
    checks++; if (bus.next_pc !== 32'h120) begin errors++; $display("FAIL blt next_pc: got %h want 120", bus.next_pc); end
    checks++; if (bus.mispredict !== 1'b1) begin errors++; $display("FAIL blt mispredict: got %b want 1", bus.mispredict); end
    drive(1, 1, 0, 0, 3'b110, 32'h100, 32'hFFFFFFFF, 32'h1, 32'h20, 0, 0);
    tick();
    checks++; if (bus.taken !== 1'b0) begin errors++; $display("FAIL bltu taken: got %b want 0", bus.taken); end
    checks++; if (bus.next_pc !== 32'h104) begin errors++; $display("FAIL bltu next_pc: got %h want 104", bus.next_pc); end
    checks++; if (bus.mispredict !== 1'b0) begin errors++; $display("FAIL bltu mispredict: got %b want 0", bus.mispredict); end
    checks++; if (bus.br_count !== 16'd1 || bus.mis_count !== 16'd1) begin errors++; $display("FAIL blt counters: got %0d/%0d want 1/1", bus.br_count, bus.mis_count); end
    bus.in_valid = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bltu drain out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.br_count !== 16'd2 || bus.mis_count !== 16'd1) begin errors++; $display("FAIL bltu counters: got %0d/%0d want 2/1", bus.br_count, bus.mis_count); end
  endtask

  task automatic test_jalr();
    drive(1, 0, 0, 1, 3'b000, 32'h500, 32'h1003, 32'h0, 32'h4, 1, 32'h1006);
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.next_pc !== 32'h1006) begin errors++; $display("FAIL jalr next_pc: got %h want 1006", bus.next_pc); end
    checks++; if (bus.taken !== 1'b1) begin errors++; $display("FAIL jalr taken: got %b want 1", bus.taken); end
    checks++; if (bus.mispredict !== 1'b0) begin errors++; $display("FAIL jalr mispredict: got %b want 0", bus.mispredict); end
    checks++; if (bus.misaligned !== 1'b1) begin errors++; $display("FAIL jalr misaligned: got %b want 1", bus.misaligned); end
    tick();
    checks++; if (bus.br_count !== 16'd3 || bus.mis_count !== 16'd1) begin errors++; $display("FAIL jalr counters: got %0d/%0d want 3/1", bus.br_count, bus.mis_count); end
  endtask

  task automatic test_wrap_illegal();
    drive(1, 1, 0, 0, 3'b000, 32'hFFFFFFFC, 32'h1, 32'h2, 32'h40, 0, 0);
    tick();
    checks++; if (bus.next_pc !== 32'h0 || bus.taken !== 1'b0) begin errors++; $display("FAIL wrap beq: got pc=%h taken=%b want 0/0", bus.next_pc, bus.taken); end
    checks++; if (bus.illegal !== 1'b0 || bus.mispredict !== 1'b0) begin errors++; $display("FAIL wrap flags: got ill=%b mis=%b want 0/0", bus.illegal, bus.mispredict); end
    drive(1, 1, 0, 0, 3'b010, 32'hFFFFFFFC, 32'h1, 32'h1, 32'h40, 0, 0);
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.illegal !== 1'b1) begin errors++; $display("FAIL illegal flag: got %b want 1", bus.illegal); end
    checks++; if (bus.taken !== 1'b0 || bus.next_pc !== 32'h0) begin errors++; $display("FAIL illegal result: got taken=%b pc=%h want 0/0", bus.taken, bus.next_pc); end
    tick();
    checks++; if (bus.br_count !== 16'd5 || bus.mis_count !== 16'd1) begin errors++; $display("FAIL wrap counters: got %0d/%0d want 5/1", bus.br_count, bus.mis_count); end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(1, 0, 1, 0, 3'b000, 32'h200, 32'h0, 32'h0, 32'h40, 1, 32'h240);
    tick();
    drive(1, 1, 0, 0, 3'b001, 32'h300, 32'h1, 32'h2, 32'hFFFFFFF8, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp in_ready[%0d]: got %b want 0", i, bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b1 || bus.next_pc !== 32'h240 || bus.mispredict !== 1'b0) begin errors++; $display("FAIL bp hold[%0d]: got v=%b pc=%h mis=%b want 1/240/0", i, bus.out_valid, bus.next_pc, bus.mispredict); end
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp release in_ready: got %b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.next_pc !== 32'h2F8 || bus.mispredict !== 1'b1) begin errors++; $display("FAIL bp second: got v=%b pc=%h mis=%b want 1/2f8/1", bus.out_valid, bus.next_pc, bus.mispredict); end
    checks++; if (bus.br_count !== 16'd6) begin errors++; $display("FAIL bp br_count first: got %0d want 6", bus.br_count); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp drain out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.br_count !== 16'd7 || bus.mis_count !== 16'd2) begin errors++; $display("FAIL bp counters: got %0d/%0d want 7/2", bus.br_count, bus.mis_count); end
  endtask

  task automatic test_no_flag();
    drive(1, 0, 0, 0, 3'b000, 32'h800, 32'h5, 32'h5, 32'h10, 1, 32'h810);
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.taken !== 1'b0 || bus.next_pc !== 32'h804 || bus.mispredict !== 1'b1) begin errors++; $display("FAIL noflag result: got t=%b pc=%h mis=%b want 0/804/1", bus.taken, bus.next_pc, bus.mispredict); end
    tick();
    checks++; if (bus.br_count !== 16'd7 || bus.mis_count !== 16'd2) begin errors++; $display("FAIL noflag counters: got %0d/%0d want 7/2", bus.br_count, bus.mis_count); end
  endtask

  task automatic test_saturate();
    bus2.is_branch = 1'b1; bus2.funct3 = 3'b000; bus2.pc = 32'h40; bus2.rs1 = 32'h7;
    bus2.rs2 = 32'h7; bus2.imm = 32'h8; bus2.pred_taken = 1'b0; bus2.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    bus2.in_valid = 1'b0;
    tick();
    checks++; if (bus2.br_count !== 2'd3) begin errors++; $display("FAIL sat br_count: got %0d want 3", bus2.br_count); end
    checks++; if (bus2.mis_count !== 2'd3) begin errors++; $display("FAIL sat mis_count: got %0d want 3", bus2.mis_count); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    drive(1, 1, 0, 0, 3'b000, 32'h900, 32'h3, 32'h3, 32'h20, 0, 0);
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rstmid held: got %b want 1", bus.out_valid); end
    bus.out_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.br_count !== 16'd0 || bus.mis_count !== 16'd0) begin errors++; $display("FAIL rstmid counters: got %0d/%0d want 0/0", bus.br_count, bus.mis_count); end
    tick();
    checks++; if (bus.br_count !== 16'd0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid after: got br=%0d rdy=%b want 0/1", bus.br_count, bus.in_ready); end
  endtask

  initial begin
    test_reset();
    test_blt_bltu();
    test_jalr();
    test_wrap_illegal();
    test_backpressure();
    test_no_flag();
    test_saturate();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
